// File: rtl/fwd_stall_ctrl.sv
// rtl/fwd_stall_ctrl.sv - operand forwarding select and load-use stall control.
// Define FWD_STALL_CTRL_FWD_EN to enable forwarding; otherwise any in-flight writer match stalls.
module fwd_stall_ctrl #(
  parameter int RAW      = 2,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 2,
  localparam int SELW    = $clog2(DEPTH + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            iss_valid,
  input  logic            iss_wr,
  input  logic [RAW-1:0]  iss_dst,
  input  logic            iss_load,
  input  logic            iss_use1,
  input  logic            iss_use2,
  input  logic [RAW-1:0]  iss_src1,
  input  logic [RAW-1:0]  iss_src2,
  input  logic            flush,
  output logic            stall,
  output logic [SELW-1:0] sel1,
  output logic [SELW-1:0] sel2,
  output logic [DEPTH-1:0] occ
);

  localparam logic [SELW-1:0] LOAD_LAT_S = SELW'(LOAD_LAT);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] ld_q;
  logic [RAW-1:0]   dst_q [DEPTH];
  logic             haz1;
  logic             haz2;

  // Index k-1 holds stage k; flush kills the stage-1 occupant as it moves to stage 2.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v_q  <= '0;
      ld_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        dst_q[k] <= '0;
      end
    end else begin
      v_q[0]   <= iss_valid & iss_wr & ~stall & ~flush;
      ld_q[0]  <= iss_load;
      dst_q[0] <= iss_dst;
      for (int k = 1; k < DEPTH; k++) begin
        v_q[k]   <= v_q[k-1] & ~(flush && (k == 1));
        ld_q[k]  <= ld_q[k-1];
        dst_q[k] <= dst_q[k-1];
      end
    end
  end

`ifdef FWD_STALL_CTRL_FWD_EN
  logic [SELW-1:0] win1;
  logic [SELW-1:0] win2;
  logic            wld1;
  logic            wld2;

  // Scan oldest to youngest so the youngest matching writer overwrites the result.
  always_comb begin
    win1 = '0;
    win2 = '0;
    wld1 = 1'b0;
    wld2 = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (v_q[k] && iss_use1 && (dst_q[k] == iss_src1)) begin
        win1 = SELW'(k + 1);
        wld1 = ld_q[k];
      end
      if (v_q[k] && iss_use2 && (dst_q[k] == iss_src2)) begin
        win2 = SELW'(k + 1);
        wld2 = ld_q[k];
      end
    end
  end

  assign haz1 = wld1 & (win1 < LOAD_LAT_S);
  assign haz2 = wld2 & (win2 < LOAD_LAT_S);
  assign sel1 = haz1 ? '0 : win1;
  assign sel2 = haz2 ? '0 : win2;
`else
  logic any1;
  logic any2;
  logic unused_cfg;

  always_comb begin
    any1 = 1'b0;
    any2 = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      any1 = any1 | (v_q[k] & iss_use1 & (dst_q[k] == iss_src1));
      any2 = any2 | (v_q[k] & iss_use2 & (dst_q[k] == iss_src2));
    end
  end

  assign haz1       = any1;
  assign haz2       = any2;
  assign sel1       = '0;
  assign sel2       = '0;
  assign unused_cfg = ^{ld_q, LOAD_LAT_S};
`endif

  assign stall = iss_valid & ~flush & (haz1 | haz2);
  assign occ   = v_q;

endmodule
